seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 25 ++
 rtl/seq_divider_div_step.sv | 32 +++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the hi/lo packing of the result word.
package seq_divider_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  // Result word is {remainder, quotient}; each field is dw bits wide.
  localparam int LO_POS = 0;

  function automatic int hi_pos(input int dw);
    return dw;
  endfunction

  function automatic int lo_pos();
    return LO_POS;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring radix-2 division iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, shift in the quotient bit.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] rem,
  input  logic [DW-1:0] quot,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_next,
  output logic [DW-1:0] quot_next
);

  logic [DW:0] trial;
  logic [DW:0] diff;

  always_comb begin
    trial = {rem, quot[DW-1]};
    diff  = trial - {1'b0, divisor};
    // A clear sign bit means the divisor fitted; the partial remainder is
    // always below the divisor, so the kept value fits back into DW bits.
    if (!diff[DW]) begin
      rem_next  = diff[DW-1:0];
      quot_next = {quot[DW-2:0], 1'b1};
    end else begin
      rem_next  = trial[DW-1:0];
      quot_next = {quot[DW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider: one quotient bit per cycle on
// magnitudes, sign fix-up on the last step, divide-by-zero short path.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t state;
  state_t state_next;

  logic [CW-1:0]   cnt;
  logic [DW-1:0]   rem;
  logic [DW-1:0]   quot;
  logic [DW-1:0]   divisor;
  logic [DW-1:0]   dividend;
  logic            neg_q;
  logic            neg_r;
  logic [2*DW-1:0] res_q;

  logic [DW-1:0]   rem_n;
  logic [DW-1:0]   quot_n;
  logic            ready_next;
  logic [2*DW-1:0] result_next;

  div_step #(.DW(DW)) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (divisor),
    .rem_next  (rem_n),
    .quot_next (quot_n)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (annul_i) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start_i) state_next = (opdata2_i == '0) ? BYZERO : ON;
        BYZERO:  state_next = END;
        ON:      if (cnt == LAST) state_next = END;
        END:     if (ready_o && !start_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The first END cycle always presents the result, so a request dropped
  // early still produces one ready pulse before returning to IDLE.
  always_comb begin
    ready_next  = 1'b0;
    result_next = '0;
    if (!annul_i && state == END && !(ready_o && !start_i)) begin
      ready_next  = 1'b1;
      result_next = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      ready_o  <= ready_next;
      result_o <= result_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
      dividend <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      res_q    <= '0;
    end else if (annul_i) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            dividend <= opdata1_i;
            neg_q    <= signed_div_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
            neg_r    <= signed_div_i & opdata1_i[DW-1];
            quot     <= (signed_div_i && opdata1_i[DW-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
            divisor  <= (signed_div_i && opdata2_i[DW-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
            rem      <= '0;
            cnt      <= '0;
          end
        end
        BYZERO: begin
          res_q[hi_pos(DW) +: DW] <= dividend;
          res_q[lo_pos() +: DW]   <= '1;
        end
        ON: begin
          rem  <= rem_n;
          quot <= quot_n;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            res_q[hi_pos(DW) +: DW] <= neg_r ? (~rem_n + 1'b1) : rem_n;
            res_q[lo_pos() +: DW]   <= neg_q ? (~quot_n + 1'b1) : quot_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (DW=32).
module tb_seq_divider;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            signed_div_i;
  logic [DW-1:0]   opdata1_i;
  logic [DW-1:0]   opdata2_i;
  logic            start_i;
  logic            annul_i;
  logic [2*DW-1:0] result_o;
  logic            ready_o;

  int checks = 0;
  int errors = 0;

  seq_divider #(.DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation with start held; optionally scramble the inputs mid-run.
  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                        input int lat, input bit scramble);
    int cyc;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    chk({name, "_accept_ready"}, 64'(ready_o), 64'd0);
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      tick();
      cyc++;
      if (scramble && cyc == 5) begin
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'h0000_0003;
        signed_div_i = ~sgn;
      end
    end
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_result"}, result_o, {r, q});
    tick();
    chk({name, "_hold"}, {63'd0, ready_o} ^ 64'(result_o != {r, q}), 64'd1);
    start_i = 1'b0;
    tick();
    chk({name, "_drop_ready"}, 64'(ready_o), 64'd0);
    chk({name, "_drop_result"}, result_o, 64'd0);
  endtask

  task automatic watch_idle(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ready_o) seen++;
    end
    chk({name, "_no_ready"}, 64'(seen), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    vecs[5]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  2};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  2};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
    vecs[9]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          33};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) tick();
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, vecs[i].lat, 1'b0);

    // Annul at iteration 10, then restart with 9/3.
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    tick();
    repeat (10) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0; start_i = 1'b0;
    chk("annul_ready", 64'(ready_o), 64'd0);
    watch_idle("annul", 40);
    run_op("restart", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0);

    // Annul has priority over a fresh request in IDLE.
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd8; opdata2_i = 32'd2;
    tick();
    start_i = 1'b0; annul_i = 1'b0;
    watch_idle("annul_prio", 40);

    // Reset mid-ON discards the operation.
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
    tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; start_i = 1'b0;
    chk("midrst_ready", 64'(ready_o), 64'd0);
    chk("midrst_result", result_o, 64'd0);
    watch_idle("midrst", 40);

    // Input changes during ON must not affect the latched operation.
    run_op("scramble", 1'b0, 32'd77, 32'd7, 32'd11, 32'd0, 33, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
